// File: rtl/frame_buffer_dual_if.sv
// Pixel-write handshake between the draw engine and the frame buffer.
interface frame_buffer_dual_if #(
  parameter int PIX_W = 5
);
  logic             wr_valid;
  logic             wr_ready;
  logic [9:0]       wr_x;
  logic [9:0]       wr_y;
  logic [PIX_W-1:0] wr_pixel;

  modport master (
    output wr_valid,
    output wr_x,
    output wr_y,
    output wr_pixel,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_x,
    input  wr_y,
    input  wr_pixel,
    output wr_ready
  );
endinterface

// File: rtl/frame_buffer_dual.sv
// Double-buffered frame store: scan-out reads the front bank while the draw
// engine fills the back bank; banks swap at frame start, optionally followed by a clear.
module frame_buffer_dual #(
  parameter int               H_RES         = 640,
  parameter int               V_RES         = 480,
  parameter int               PIX_W         = 5,
  parameter logic [PIX_W-1:0] TRANSP_KEY    = 5'h15,
  parameter bit               CLEAR_ON_SWAP = 1'b1,
  parameter logic [PIX_W-1:0] CLEAR_VAL     = '0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_start,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  output logic [PIX_W-1:0]      pixelOut,
  frame_buffer_dual_if.slave    wr,
  input  logic                  swap_req,
  output logic                  swap_pending,
  output logic                  front_sel
);

  localparam int NPIX = H_RES * V_RES;
  localparam int AW   = $clog2(2 * NPIX);
  localparam int CW   = $clog2(NPIX + 1);

  typedef enum logic {ACCEPT, CLEAR} state_t;

  state_t state, state_n;
  logic [CW-1:0] clear_cnt;
  logic do_swap;

  logic [PIX_W-1:0] mem [0:2*NPIX-1];

  logic             rd_in_range;
  logic [AW-1:0]    rd_addr;
  logic             wr_in_range;
  logic             wr_fire;
  logic             wr_keep;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [PIX_W-1:0] mem_wdata;

  // Linear address kept in 32 bits so the row product never truncates.
  function automatic logic [AW-1:0] pix_addr(input logic bank,
                                             input logic [9:0] x,
                                             input logic [9:0] y);
    logic [31:0] lin;
    lin = 32'(y) * 32'(H_RES) + 32'(x);
    if (bank) lin = lin + 32'(NPIX);
    return lin[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] clear_addr(input logic bank,
                                               input logic [CW-1:0] cnt);
    logic [31:0] lin;
    lin = 32'(cnt);
    if (bank) lin = lin + 32'(NPIX);
    return lin[AW-1:0];
  endfunction

  always_comb begin
    rd_in_range = (32'(DrawX) < 32'(H_RES)) && (32'(DrawY) < 32'(V_RES));
    rd_addr     = pix_addr(front_sel, DrawX, DrawY);
    wr_in_range = (32'(wr.wr_x) < 32'(H_RES)) && (32'(wr.wr_y) < 32'(V_RES));
    wr_fire     = wr.wr_valid && wr.wr_ready;
    wr_keep     = wr_fire && wr_in_range && (wr.wr_pixel != TRANSP_KEY);
  end

  // Draw writes and clear writes share one write port; they never coincide
  // because the draw side is not ready while clearing.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = pix_addr(!front_sel, wr.wr_x, wr.wr_y);
    mem_wdata = wr.wr_pixel;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clear_addr(!front_sel, clear_cnt);
      mem_wdata = CLEAR_VAL;
    end else if (wr_keep) begin
      mem_we = 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    do_swap     = 1'b0;
    wr.wr_ready = 1'b0;
    case (state)
      ACCEPT: begin
        wr.wr_ready = 1'b1;
        if (frame_start && swap_pending) begin
          do_swap = 1'b1;
          if (CLEAR_ON_SWAP) state_n = CLEAR;
        end
      end
      CLEAR: begin
        if (clear_cnt == CW'(NPIX - 1)) state_n = ACCEPT;
      end
      default: state_n = ACCEPT;
    endcase
  end

  // A fresh request in the swap cycle itself is kept for the next frame.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= ACCEPT;
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      clear_cnt    <= '0;
    end else begin
      state <= state_n;
      if (do_swap) front_sel <= !front_sel;
      if (swap_req) swap_pending <= 1'b1;
      else if (do_swap) swap_pending <= 1'b0;
      if (do_swap || state_n != CLEAR) clear_cnt <= '0;
      else clear_cnt <= clear_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) pixelOut <= '0;
    else if (rd_in_range) pixelOut <= mem[rd_addr];
    else pixelOut <= '0;
  end

endmodule

// File: tb/tb_frame_buffer_dual.sv
// Directed bench for frame_buffer_dual in an 8x4 configuration with clear-on-swap.
module tb_frame_buffer_dual;

  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [9:0]    draw_x = '0;
  logic [9:0]    draw_y = '0;
  logic [PW-1:0] pixel_out;
  logic          swap_req = 1'b0;
  logic          swap_pending;
  logic          front_sel;
  int            checks = 0;
  int            failures = 0;
  int            clear_len;

  frame_buffer_dual_if #(.PIX_W(PW)) wr_bus();

  frame_buffer_dual #(
    .H_RES(8), .V_RES(4), .PIX_W(PW), .TRANSP_KEY(5'h15),
    .CLEAR_ON_SWAP(1'b1), .CLEAR_VAL(5'h03)
  ) dut (
    .Clk(clk),
    .Reset(rst_n),
    .frame_start(frame_start),
    .DrawX(draw_x),
    .DrawY(draw_y),
    .pixelOut(pixel_out),
    .wr(wr_bus.slave),
    .swap_req(swap_req),
    .swap_pending(swap_pending),
    .front_sel(front_sel)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One pixel write; ready must already be high so the transfer takes one cycle.
  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y,
                               input logic [PW-1:0] pix);
    @(negedge clk);
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_x     = x;
    wr_bus.wr_y     = y;
    wr_bus.wr_pixel = pix;
    checkOutput("wr_ready_1cyc", 32'(wr_bus.wr_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    wr_bus.wr_valid = 1'b0;
  endtask

  task automatic readPixel(input string tag, input logic [9:0] x,
                           input logic [9:0] y, input logic [PW-1:0] expected);
    @(negedge clk);
    draw_x = x;
    draw_y = y;
    @(negedge clk);
    checkOutput(tag, 32'(pixel_out), 32'(expected));
  endtask

  task automatic pulseControl(input logic sr, input logic fs);
    @(negedge clk);
    swap_req    = sr;
    frame_start = fs;
    @(negedge clk);
    swap_req    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic waitClearDone(output int count);
    count = 0;
    while (!wr_bus.wr_ready && count < 200) begin
      count++;
      @(negedge clk);
    end
  endtask

  initial begin
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_x     = '0;
    wr_bus.wr_y     = '0;
    wr_bus.wr_pixel = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_pixel", 32'(pixel_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_front_sel", 32'(front_sel), 32'd0);
    checkOutput("rst_swap_pending", 32'(swap_pending), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_bus.wr_ready), 32'd1);

    // Fill back bank 1, including a transparent and two out-of-range writes.
    applyStimulus(10'd3, 10'd2, 5'h0A);
    applyStimulus(10'd1, 10'd1, 5'h07);
    applyStimulus(10'd0, 10'd0, 5'h02);
    applyStimulus(10'd0, 10'd1, 5'h01);
    applyStimulus(10'd1, 10'd1, 5'h15);
    applyStimulus(10'd8, 10'd0, 5'h1F);
    applyStimulus(10'd0, 10'd4, 5'h1F);

    pulseControl(1'b1, 1'b1);
    checkOutput("same_cycle_no_swap", 32'(front_sel), 32'd0);
    checkOutput("same_cycle_pending", 32'(swap_pending), 32'd1);

    pulseControl(1'b0, 1'b1);
    checkOutput("swap1_front_sel", 32'(front_sel), 32'd1);
    checkOutput("swap1_pending_clr", 32'(swap_pending), 32'd0);
    waitClearDone(clear_len);
    checkOutput("clear_len_1", 32'(clear_len), 32'd32);

    readPixel("rd_3_2", 10'd3, 10'd2, 5'h0A);
    readPixel("rd_transp_kept", 10'd1, 10'd1, 5'h07);
    readPixel("rd_0_0", 10'd0, 10'd0, 5'h02);
    readPixel("rd_oor_no_alias", 10'd0, 10'd1, 5'h01);
    readPixel("rd_x9_zero", 10'd9, 10'd0, 5'h00);
    readPixel("rd_y4_zero", 10'd0, 10'd4, 5'h00);

    // Swap back to bank 0; issue a request and a frame start mid-clear.
    pulseControl(1'b1, 1'b0);
    pulseControl(1'b0, 1'b1);
    checkOutput("swap2_front_sel", 32'(front_sel), 32'd0);
    repeat (4) @(negedge clk);
    pulseControl(1'b1, 1'b0);
    checkOutput("clr_req_pending", 32'(swap_pending), 32'd1);
    pulseControl(1'b0, 1'b1);
    checkOutput("clr_fs_ignored", 32'(front_sel), 32'd0);
    checkOutput("clr_fs_pending", 32'(swap_pending), 32'd1);
    waitClearDone(clear_len);
    checkOutput("clear_len_2", 32'(clear_len), 32'd24);

    for (int yy = 0; yy < 4; yy++) begin
      for (int xx = 0; xx < 8; xx++) begin
        readPixel("rd_cleared", 10'(xx), 10'(yy), 5'h03);
      end
    end

    applyStimulus(10'd1, 10'd0, 5'h0E);
    applyStimulus(10'd2, 10'd3, 5'h0C);
    pulseControl(1'b0, 1'b1);
    checkOutput("swap3_front_sel", 32'(front_sel), 32'd1);
    checkOutput("swap3_pending_clr", 32'(swap_pending), 32'd0);
    readPixel("rd_during_clear", 10'd1, 10'd0, 5'h0E);
    waitClearDone(clear_len);

    // Abort the clear of bank 1 with reset at clear count 10.
    pulseControl(1'b1, 1'b0);
    pulseControl(1'b0, 1'b1);
    checkOutput("swap4_front_sel", 32'(front_sel), 32'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_front_sel", 32'(front_sel), 32'd0);
    checkOutput("abort_pending", 32'(swap_pending), 32'd0);
    checkOutput("abort_wr_ready", 32'(wr_bus.wr_ready), 32'd1);

    pulseControl(1'b1, 1'b0);
    pulseControl(1'b0, 1'b1);
    checkOutput("swap5_front_sel", 32'(front_sel), 32'd1);
    readPixel("partial_cleared", 10'd1, 10'd0, 5'h03);
    readPixel("partial_kept", 10'd2, 10'd3, 5'h0C);
    waitClearDone(clear_len);
    checkOutput("clear_len_5", 32'(clear_len), 32'd28);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/frame_buffer_dual.md
Name: frame_buffer_dual

Overview:
- Parametrised double-buffered frame buffer between the sprite/tile draw engine (writer) and the VGA scan-out path (reader).
- Scan-out always reads the front bank. The draw engine writes the back bank through a valid/ready handshake.
- Banks swap only at frame start, on request. An optional hardware clear of the new back bank runs after each swap.
- Adds transparent-key write suppression and out-of-range rejection.

Parameters:
- H_RES, 640, visible pixels per line.
- V_RES, 480, visible lines per frame.
- PIX_W, 5, encoded pixel width in bits.
- TRANSP_KEY, 5'h15, writes carrying this value are accepted but not stored.
- CLEAR_ON_SWAP, 1, 1 = fill the new back bank with CLEAR_VAL after each swap.
- CLEAR_VAL, 0, fill value, PIX_W bits.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- DrawX  in  10  scan-out column.
- DrawY  in  10  scan-out row.
- pixelOut  out  PIX_W  front-bank pixel at (DrawX, DrawY), registered.
- wr_valid  in  1  draw engine presents a pixel write.
- wr_ready  out  1  block can accept a write this cycle.
- wr_x  in  10  write column.
- wr_y  in  10  write row.
- wr_pixel  in  PIX_W  write data.
- swap_req  in  1  one-cycle pulse: back bank complete, swap at next frame_start.
- swap_pending  out  1  swap requested, not yet performed.
- front_sel  out  1  index of the current front bank.

Behaviour:
- Storage: two banks of H_RES*V_RES words, PIX_W bits each.
- Address: bank*H_RES*V_RES + y*H_RES + x, computed at width $clog2(2*H_RES*V_RES) with no truncation of the y*H_RES product.
- Read path:
  - pixelOut is valid 1 Clk after DrawX/DrawY are presented.
  - If DrawX >= H_RES or DrawY >= V_RES, pixelOut = 0 on that following cycle.
- Write path:
  - A transfer occurs when wr_valid && wr_ready on a rising Clk edge.
  - The accepted pixel is stored in the back bank (!front_sel) unless either drop condition holds: wr_pixel == TRANSP_KEY, or wr_x >= H_RES, or wr_y >= V_RES.
  - Dropped writes still complete the handshake.
- FSM states: ACCEPT, CLEAR.
- ACCEPT:
  - wr_ready = 1.
  - On frame_start with swap_pending: front_sel toggles and swap_pending clears.
  - Then, if CLEAR_ON_SWAP, go to CLEAR with the clear counter at 0; otherwise stay in ACCEPT.
  - Any write accepted in the swap cycle targets the pre-swap back bank. That bank becomes the front bank that cycle.
- CLEAR:
  - wr_ready = 0.
  - Each cycle writes CLEAR_VAL to the back bank at counter address, then increments the counter.
  - After address H_RES*V_RES-1 is written, return to ACCEPT.
  - Duration is exactly H_RES*V_RES cycles.
- swap_pending:
  - Set on swap_req.
  - Cleared only when the swap is performed.
  - A swap_req during CLEAR is latched and honoured at a frame_start after CLEAR ends.
  - frame_start during CLEAR is ignored for swapping.
  - swap_req and frame_start in the same cycle with swap_pending=0: no swap this frame; swap_pending=1 afterwards.
- Reads never stall. The front bank is never written, except for a write accepted in the swap cycle itself, which is permitted.
- Reset (asynchronous assert, synchronous release):
  - front_sel=0, swap_pending=0, state=ACCEPT, clear counter=0, pixelOut=0, wr_ready=1 after release.
  - Bank contents are not cleared by reset.
  - Reset asserted mid-CLEAR aborts the clear; the partial fill remains.
- Memory is inferred as simple dual-port synchronous RAM. Read-during-write to the same address returns old data; this cannot occur in normal operation because the banks differ.

Test Plan:
- Small config H_RES=8, V_RES=4: write (3,2)=5'h0A to back bank 1, pulse swap_req, then frame_start, then read (3,2) -> pixelOut=5'h0A one cycle later and front_sel=1.
- Write (1,1)=5'h15 over an existing 5'h07, then swap -> read returns 5'h07, and the handshake completed in 1 cycle.
- Write at (8,0) and at (0,4) -> accepted, no bank change. Read at DrawX=9 -> pixelOut=0.
- CLEAR_ON_SWAP=1, CLEAR_VAL=5'h03: after swap, wr_ready is low for exactly 32 cycles. A second swap then shows all 32 pixels = 5'h03.
- swap_req during CLEAR, frame_start also during CLEAR -> no swap, swap_pending stays 1. The next frame_start after CLEAR swaps.
- Deassert Reset for 1 cycle at clear count 10 -> front_sel=0, swap_pending=0, wr_ready=1 after release, no further clear writes.
